fog_err_demod_acc: RTL and testbench

- Digital demodulator feeding the feedback step generator of the closed-loop FOG.
- Integrates signed ADC photodetector samples separately over the high and low halves of the square-wave modulation, skipping a settling window after each polarity edge.
- On each modulation-period trigger it outputs err = sum_H - sum_L with a one-cycle valid strobe.
- Modulation generator status/trigger go in; o_err drives the feedback step generator's i_err.

---
 rtl/fog_err_demod_acc_if.sv | 28 ++
 rtl/fog_err_demod_acc.sv | 148 ++++++++++++++
 tb/tb_fog_err_demod_acc.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fog_err_demod_acc_if.sv
// Sample/modulation/result bundle between the modulation front end, the
// demodulating accumulator and the feedback step generator.
interface fog_err_demod_acc_if #(
    parameter int ADC_BIT = 14,
    parameter int ERR_BIT = 32,
    parameter int CNT_BIT = 16
);
    logic signed [ADC_BIT-1:0] i_adc;
    logic                      i_adc_vld;
    logic                      i_status;
    logic                      i_trig;
    logic signed [ERR_BIT-1:0] o_err;
    logic                      o_err_vld;
    logic        [CNT_BIT-1:0] o_cnt_H;
    logic        [CNT_BIT-1:0] o_cnt_L;
    logic                      o_short;
    logic                      o_sat;

    modport master (
        output i_adc, i_adc_vld, i_status, i_trig,
        input  o_err, o_err_vld, o_cnt_H, o_cnt_L, o_short, o_sat
    );

    modport slave (
        input  i_adc, i_adc_vld, i_status, i_trig,
        output o_err, o_err_vld, o_cnt_H, o_cnt_L, o_short, o_sat
    );
endinterface

// File: rtl/fog_err_demod_acc.sv
// FOG square-wave demodulator: integrates ADC samples per modulation half
// (after a settling skip) and strobes err = sum_H - sum_L on each period trigger.
module fog_err_demod_acc #(
    parameter int ADC_BIT = 14,
    parameter int ERR_BIT = 32,
    parameter int CNT_BIT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [CNT_BIT-1:0] i_skip_cnt,
    input  logic [CNT_BIT-1:0] i_avg_cnt,
    fog_err_demod_acc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SKIP, ACC, HOLD} state_t;

    function automatic logic ovf(input logic signed [ERR_BIT:0] x);
        return x[ERR_BIT] != x[ERR_BIT-1];
    endfunction

    function automatic logic signed [ERR_BIT-1:0] sat(input logic signed [ERR_BIT:0] x);
        if (!ovf(x)) return x[ERR_BIT-1:0];
        return x[ERR_BIT] ? {1'b1, {(ERR_BIT-1){1'b0}}} : {1'b0, {(ERR_BIT-1){1'b1}}};
    endfunction

    function automatic logic [CNT_BIT-1:0] cnt_inc(input logic [CNT_BIT-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_t                    r_state;
    logic                      r_status_d, r_sat;
    logic        [CNT_BIT-1:0] r_skip_rem, r_avg_lim, r_cnt_H, r_cnt_L;
    logic signed [ERR_BIT-1:0] r_sum_H, r_sum_L;
    logic signed [ERR_BIT-1:0] r_err;
    logic                      r_err_vld, r_short, r_sat_o;
    logic        [CNT_BIT-1:0] r_o_cnt_H, r_o_cnt_L;

    logic                      w_edge, w_arm, w_load, w_take, w_sat_nx;
    logic signed [ERR_BIT:0]   w_adc_x, w_add_H, w_add_L, w_diff;
    state_t                    w_st, w_st_nx;
    logic        [CNT_BIT-1:0] w_skip, w_skip_nx, w_lim, w_cnt_H_nx, w_cnt_L_nx;
    logic signed [ERR_BIT-1:0] w_sum_H_nx, w_sum_L_nx;

    assign w_edge  = bus.i_status ^ r_status_d;
    assign w_arm   = (r_state == IDLE) && bus.i_trig;
    // The arming trigger opens a skip window like an edge, but accumulates nothing itself.
    assign w_load  = w_arm || ((r_state != IDLE) && w_edge);
    assign w_adc_x = {{(ERR_BIT+1-ADC_BIT){bus.i_adc[ADC_BIT-1]}}, bus.i_adc};
    assign w_add_H = {r_sum_H[ERR_BIT-1], r_sum_H} + w_adc_x;
    assign w_add_L = {r_sum_L[ERR_BIT-1], r_sum_L} + w_adc_x;

    always_comb begin
        w_st   = r_state;
        w_skip = r_skip_rem;
        w_lim  = r_avg_lim;
        if (w_load) begin
            w_st   = SKIP;
            w_skip = i_skip_cnt;
            w_lim  = i_avg_cnt;
        end
        if (w_st == SKIP && w_skip == '0) w_st = ACC;

        w_st_nx    = w_st;
        w_skip_nx  = w_skip;
        w_take     = 1'b0;
        w_sum_H_nx = r_sum_H;
        w_sum_L_nx = r_sum_L;
        w_cnt_H_nx = r_cnt_H;
        w_cnt_L_nx = r_cnt_L;
        w_sat_nx   = r_sat;

        if (bus.i_adc_vld) begin
            if (w_st == SKIP) begin
                w_skip_nx = w_skip - 1'b1;
                if (w_skip_nx == '0) w_st_nx = ACC;
            end else if (w_st == ACC && !w_arm) begin
                w_take = 1'b1;
            end
        end

        // Current i_status selects the half; it equals status_d except on edge cycles.
        if (w_take && bus.i_status) begin
            w_sum_H_nx = sat(w_add_H);
            w_cnt_H_nx = cnt_inc(r_cnt_H);
            w_sat_nx   = r_sat | ovf(w_add_H);
            if (w_lim != '0 && w_cnt_H_nx == w_lim) w_st_nx = HOLD;
        end else if (w_take) begin
            w_sum_L_nx = sat(w_add_L);
            w_cnt_L_nx = cnt_inc(r_cnt_L);
            w_sat_nx   = r_sat | ovf(w_add_L);
            if (w_lim != '0 && w_cnt_L_nx == w_lim) w_st_nx = HOLD;
        end
    end

    assign w_diff = {w_sum_H_nx[ERR_BIT-1], w_sum_H_nx} - {w_sum_L_nx[ERR_BIT-1], w_sum_L_nx};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_status_d <= 1'b0;
            r_skip_rem <= '0;
            r_avg_lim  <= '0;
            r_cnt_H    <= '0;
            r_cnt_L    <= '0;
            r_sum_H    <= '0;
            r_sum_L    <= '0;
            r_sat      <= 1'b0;
            r_err      <= '0;
            r_err_vld  <= 1'b0;
            r_o_cnt_H  <= '0;
            r_o_cnt_L  <= '0;
            r_short    <= 1'b0;
            r_sat_o    <= 1'b0;
        end else begin
            r_status_d <= bus.i_status;
            r_state    <= w_st_nx;
            r_skip_rem <= w_skip_nx;
            r_avg_lim  <= w_lim;
            r_err_vld  <= 1'b0;
            // Period boundary: publish the result including this cycle's sample, then restart.
            if (bus.i_trig && r_state != IDLE) begin
                r_err     <= sat(w_diff);
                r_err_vld <= 1'b1;
                r_o_cnt_H <= w_cnt_H_nx;
                r_o_cnt_L <= w_cnt_L_nx;
                r_short   <= (w_cnt_H_nx == '0) || (w_cnt_L_nx == '0);
                r_sat_o   <= w_sat_nx | ovf(w_diff);
                r_sum_H   <= '0;
                r_sum_L   <= '0;
                r_cnt_H   <= '0;
                r_cnt_L   <= '0;
                r_sat     <= 1'b0;
            end else begin
                r_sum_H   <= w_sum_H_nx;
                r_sum_L   <= w_sum_L_nx;
                r_cnt_H   <= w_cnt_H_nx;
                r_cnt_L   <= w_cnt_L_nx;
                r_sat     <= w_sat_nx;
            end
        end
    end

    assign bus.o_err     = r_err;
    assign bus.o_err_vld = r_err_vld;
    assign bus.o_cnt_H   = r_o_cnt_H;
    assign bus.o_cnt_L   = r_o_cnt_L;
    assign bus.o_short   = r_short;
    assign bus.o_sat     = r_sat_o;
endmodule

// File: tb/tb_fog_err_demod_acc.sv
// Scoreboard bench: 100-clock modulation halves, expected results queued at each
// trigger and compared when the one-cycle strobe appears.
module tb_fog_err_demod_acc;
    localparam int ADC_BIT = 14;
    localparam int ERR_BIT = 16;
    localparam int CNT_BIT = 16;
    localparam int EMAX    = 2**(ERR_BIT-1) - 1;
    localparam int EMIN    = -(2**(ERR_BIT-1));

    typedef struct {
        int due;
        int err;
        int cH;
        int cL;
        bit shrt;
        bit sat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [CNT_BIT-1:0] skip_cnt = '0;
    logic [CNT_BIT-1:0] avg_cnt = '0;
    int                 n_chk = 0;
    int                 n_err = 0;
    int                 cyc = 0;
    bit                 armed = 1'b0;
    int                 cur_nH, cur_sH, cur_nL, cur_sL;
    exp_t               q[$];

    fog_err_demod_acc_if #(.ADC_BIT(ADC_BIT), .ERR_BIT(ERR_BIT), .CNT_BIT(CNT_BIT)) bus ();

    fog_err_demod_acc #(.ADC_BIT(ADC_BIT), .ERR_BIT(ERR_BIT), .CNT_BIT(CNT_BIT)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_skip_cnt (skip_cnt),
        .i_avg_cnt  (avg_cnt),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int clampe(input int v);
        if (v > EMAX) return EMAX;
        if (v < EMIN) return EMIN;
        return v;
    endfunction

    function automatic int hc(input int s, input int a);
        int n;
        n = (s >= 100) ? 0 : 100 - s;
        if (a != 0 && a < n) n = a;
        return n;
    endfunction

    task automatic push_exp(input int nH, input int sH, input int nL, input int sL);
        exp_t e;
        int ch, cl, d;
        ch     = clampe(sH);
        cl     = clampe(sL);
        d      = ch - cl;
        e.due  = cyc + 1;
        e.err  = clampe(d);
        e.cH   = nH;
        e.cL   = nL;
        e.shrt = (nH == 0) || (nL == 0);
        e.sat  = (ch != sH) || (cl != sL) || (e.err != d);
        q.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        bit   ev;
        ev = (q.size() != 0) && (q[0].due == cyc);
        chk("err_vld", bus.o_err_vld, ev);
        if (ev) begin
            e = q.pop_front();
            chk("err",   bus.o_err,   e.err);
            chk("cnt_H", bus.o_cnt_H, e.cH);
            chk("cnt_L", bus.o_cnt_L, e.cL);
            chk("short", bus.o_short, e.shrt);
            chk("sat",   bus.o_sat,   e.sat);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_err"},   bus.o_err,   0);
        chk({tag, "_cnt_H"}, bus.o_cnt_H, 0);
        chk({tag, "_cnt_L"}, bus.o_cnt_L, 0);
        chk({tag, "_short"}, bus.o_short, 0);
        chk({tag, "_sat"},   bus.o_sat,   0);
    endtask

    // mode 0: plain period; 1: reset pulse at sample 40 of the high half;
    // 2: back-to-back triggers at samples 50 and 51 of the high half.
    task automatic run_period(input int vh, input int vl, input int s,
                              input int aH, input int aL, input int mode);
        logic st;
        for (int c = 0; c < 200; c++) begin
            st = (c < 100);
            @(posedge clk);
            #1;
            if (mode == 1 && c == 41) chk_zero("midrst");
            rst = (mode == 1 && c == 40);
            if (rst) armed = 1'b0;
            bus.i_status  = st;
            bus.i_adc     = ADC_BIT'(st ? vh : vl);
            bus.i_adc_vld = 1'b1;
            skip_cnt      = CNT_BIT'(s);
            avg_cnt       = CNT_BIT'((c < 50) ? aH : aL);
            bus.i_trig    = (c == 0) || (mode == 2 && (c == 50 || c == 51));
            if (bus.i_trig) begin
                if (!armed) begin
                    armed = 1'b1;
                end else if (c == 0) begin
                    if (s == 0) begin
                        cur_nH++;
                        cur_sH += vh;
                    end
                    push_exp(cur_nH, cur_sH, cur_nL, cur_sL);
                end else if (c == 50) begin
                    push_exp(51 - s, (51 - s) * vh, 0, 0);
                end else begin
                    push_exp(1, vh, 0, 0);
                end
                if (c == 0) begin
                    cur_nH = (s == 0) ? 99 : hc(s, aH);
                    cur_sH = cur_nH * vh;
                    cur_nL = hc(s, aL);
                    cur_sL = cur_nL * vl;
                end
                if (c == 51) begin
                    cur_nH = 48;
                    cur_sH = 48 * vh;
                end
            end
        end
    endtask

    initial begin
        bus.i_adc     = '0;
        bus.i_adc_vld = 1'b0;
        bus.i_status  = 1'b0;
        bus.i_trig    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            bus.i_adc_vld = 1'b1;
            bus.i_adc     = ADC_BIT'(55);
        end

        repeat (4) run_period(100, -100, 10, 0, 0, 0);
        repeat (2) run_period(100, -100, 10, 50, 50, 0);
        run_period(100, -100, 10, 50, 20, 0);
        run_period(100, -100, 10, 20, 20, 0);
        repeat (2) run_period(100, -100, 120, 0, 0, 0);
        repeat (2) run_period(8191, -8192, 0, 0, 0, 0);
        run_period(100, -100, 10, 0, 0, 2);
        run_period(100, -100, 10, 0, 0, 0);
        run_period(100, -100, 10, 0, 0, 1);
        run_period(100, -100, 10, 0, 0, 0);
        run_period(100, -100, 10, 0, 0, 0);

        @(posedge clk);
        #1;
        bus.i_status = 1'b1;
        bus.i_adc    = ADC_BIT'(100);
        bus.i_trig   = 1'b1;
        push_exp(cur_nH, cur_sH, cur_nL, cur_sL);
        @(posedge clk);
        #1;
        bus.i_trig = 1'b0;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
